// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM states, widths.
package ex_pkg;

  localparam int EX_DATA_W = 32;
  localparam int EX_ADDR_W = 5;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_MUL = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ex_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W
// bits of a*b available on product once the final step has been taken.
module mul_iter
  import ex_pkg::*;
#(
  parameter int DATA_W    = EX_DATA_W,
  parameter int MUL_ITERS = DATA_W
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(MUL_ITERS + 1);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              last_step;

  // done marks the cycle in which the final step is taken, so the caller can
  // schedule its result cycle directly after it.
  assign last_step = busy_q && (cnt_q == CNT_W'(MUL_ITERS - 1));

  // Operand load, per-cycle shift-add step and iteration counter.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (abort) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last_step) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = last_step;
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, branch resolve, destination select and
// the EX/MEM register. MUL runs on an iterative multiplier while the stage
// stalls upstream and feeds bubbles downstream.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W    = EX_DATA_W,
  parameter int ADDR_W    = EX_ADDR_W,
  parameter int MUL_ITERS = DATA_W
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              Valid_In,
  input  logic              Flush_In,
  input  logic              RegWriteEN_In,
  input  logic              Mem2RegSEL_In,
  input  logic              MemWriteEN_In,
  input  logic              Branch_In,
  input  logic [3:0]        ALUCtrl_In,
  input  logic              ALUSrc_In,
  input  logic              RegDstSEL_In,
  input  logic [DATA_W-1:0] RegData1_In,
  input  logic [DATA_W-1:0] RegData2_In,
  input  logic [DATA_W-1:0] ImmSignExt_In,
  input  logic [ADDR_W-1:0] RTAddr_In,
  input  logic [ADDR_W-1:0] RDAddr_In,
  output logic              Stall_Out,
  output logic              Valid_Out,
  output logic              RegWriteEN_Out,
  output logic              Mem2RegSEL_Out,
  output logic              MemWriteEN_Out,
  output logic              BranchTaken_Out,
  output logic              Zero_Out,
  output logic [DATA_W-1:0] ALUResult_Out,
  output logic [DATA_W-1:0] StoreData_Out,
  output logic [ADDR_W-1:0] WriteAddr_Out
);

  localparam int SHAMT_W = $clog2(DATA_W);

  ex_state_e         state_q;
  ex_state_e         state_d;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [ADDR_W-1:0] wr_addr;
  logic [SHAMT_W-1:0] shamt;
  logic              is_mul;
  logic              issue_mul;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic              deliver;
  logic [DATA_W-1:0] res_sel;
  logic              res_zero;

  assign op_b    = ALUSrc_In ? ImmSignExt_In : RegData2_In;
  assign wr_addr = RegDstSEL_In ? RDAddr_In : RTAddr_In;
  assign shamt   = RegData1_In[SHAMT_W-1:0];
  assign is_mul  = (ALUCtrl_In == ALU_MUL);

  // A flush in the issue cycle kills the MUL before it ever starts.
  assign issue_mul = (state_q == IDLE) && Valid_In && is_mul && !Flush_In;

  // Stall is gated by reset so upstream is released while RESET_N is low,
  // even if it still presents a MUL.
  assign Stall_Out = RESET_N && !Flush_In && (issue_mul || (state_q == BUSY));

  // Single-cycle ALU; MUL and unused codes yield zero here.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_In)
      ALU_ADD: alu_res = RegData1_In + op_b;
      ALU_SUB: alu_res = RegData1_In - op_b;
      ALU_AND: alu_res = RegData1_In & op_b;
      ALU_OR:  alu_res = RegData1_In | op_b;
      ALU_XOR: alu_res = RegData1_In ^ op_b;
      ALU_NOR: alu_res = ~(RegData1_In | op_b);
      ALU_SLT: alu_res[0] = ($signed(RegData1_In) < $signed(op_b));
      ALU_SLL: alu_res = op_b << shamt;
      ALU_SRL: alu_res = op_b >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(op_b) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  mul_iter #(
    .DATA_W    (DATA_W),
    .MUL_ITERS (MUL_ITERS)
  ) u_mul (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .start   (issue_mul),
    .abort   (Flush_In),
    .a       (RegData1_In),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // FSM state register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: issue -> BUSY -> DONE on the final step -> IDLE; flush aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (issue_mul) state_d = BUSY;
      BUSY: begin
        if (!mul_busy) begin
          state_d = IDLE;
        end else if (mul_done) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Flush_In) begin
      state_d = IDLE;
    end
  end

  // Decide whether this cycle hands a real instruction to EX/MEM, and with
  // which result; everything else becomes a bubble.
  always_comb begin
    deliver = 1'b0;
    res_sel = alu_res;
    if (!Flush_In) begin
      if ((state_q == IDLE) && Valid_In && !is_mul) begin
        deliver = 1'b1;
      end else if (state_q == DONE) begin
        deliver = 1'b1;
        res_sel = mul_product;
      end
    end
  end

  assign res_zero = (res_sel == '0);

  // EX/MEM register; bubbles clear only the side-effecting controls and hold data.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      Valid_Out       <= 1'b0;
      RegWriteEN_Out  <= 1'b0;
      Mem2RegSEL_Out  <= 1'b0;
      MemWriteEN_Out  <= 1'b0;
      BranchTaken_Out <= 1'b0;
      Zero_Out        <= 1'b0;
      ALUResult_Out   <= '0;
      StoreData_Out   <= '0;
      WriteAddr_Out   <= '0;
    end else if (deliver) begin
      Valid_Out       <= 1'b1;
      RegWriteEN_Out  <= RegWriteEN_In;
      Mem2RegSEL_Out  <= Mem2RegSEL_In;
      MemWriteEN_Out  <= MemWriteEN_In;
      BranchTaken_Out <= Branch_In && res_zero;
      Zero_Out        <= res_zero;
      ALUResult_Out   <= res_sel;
      StoreData_Out   <= RegData2_In;
      WriteAddr_Out   <= wr_addr;
    end else begin
      Valid_Out       <= 1'b0;
      RegWriteEN_Out  <= 1'b0;
      MemWriteEN_Out  <= 1'b0;
      BranchTaken_Out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops, hand-written
// sequences for MUL timing, flush abort and asynchronous reset.
module tb_ex_stage;

  logic        CLOCK;
  logic        RESET_N;
  logic        Valid_In;
  logic        Flush_In;
  logic        RegWriteEN_In;
  logic        Mem2RegSEL_In;
  logic        MemWriteEN_In;
  logic        Branch_In;
  logic [3:0]  ALUCtrl_In;
  logic        ALUSrc_In;
  logic        RegDstSEL_In;
  logic [31:0] RegData1_In;
  logic [31:0] RegData2_In;
  logic [31:0] ImmSignExt_In;
  logic [4:0]  RTAddr_In;
  logic [4:0]  RDAddr_In;
  logic        Stall_Out;
  logic        Valid_Out;
  logic        RegWriteEN_Out;
  logic        Mem2RegSEL_Out;
  logic        MemWriteEN_Out;
  logic        BranchTaken_Out;
  logic        Zero_Out;
  logic [31:0] ALUResult_Out;
  logic [31:0] StoreData_Out;
  logic [4:0]  WriteAddr_Out;

  int n_checks = 0;
  int n_errors = 0;

  ex_stage #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .MUL_ITERS (32)
  ) dut (
    .CLOCK           (CLOCK),
    .RESET_N         (RESET_N),
    .Valid_In        (Valid_In),
    .Flush_In        (Flush_In),
    .RegWriteEN_In   (RegWriteEN_In),
    .Mem2RegSEL_In   (Mem2RegSEL_In),
    .MemWriteEN_In   (MemWriteEN_In),
    .Branch_In       (Branch_In),
    .ALUCtrl_In      (ALUCtrl_In),
    .ALUSrc_In       (ALUSrc_In),
    .RegDstSEL_In    (RegDstSEL_In),
    .RegData1_In     (RegData1_In),
    .RegData2_In     (RegData2_In),
    .ImmSignExt_In   (ImmSignExt_In),
    .RTAddr_In       (RTAddr_In),
    .RDAddr_In       (RDAddr_In),
    .Stall_Out       (Stall_Out),
    .Valid_Out       (Valid_Out),
    .RegWriteEN_Out  (RegWriteEN_Out),
    .Mem2RegSEL_Out  (Mem2RegSEL_Out),
    .MemWriteEN_Out  (MemWriteEN_Out),
    .BranchTaken_Out (BranchTaken_Out),
    .Zero_Out        (Zero_Out),
    .ALUResult_Out   (ALUResult_Out),
    .StoreData_Out   (StoreData_Out),
    .WriteAddr_Out   (WriteAddr_Out)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        valid, br, rw, mw, m2r, src, dst;
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic [4:0]  rt, rd;
    logic        e_valid;
    logic [31:0] e_res;
    logic        e_zero, e_bt;
    logic [4:0]  e_waddr;
    logic        e_rw, e_mw, e_m2r;
    logic [31:0] e_store;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Valid_In      = v.valid;
    Branch_In     = v.br;
    RegWriteEN_In = v.rw;
    MemWriteEN_In = v.mw;
    Mem2RegSEL_In = v.m2r;
    ALUSrc_In     = v.src;
    RegDstSEL_In  = v.dst;
    ALUCtrl_In    = v.op;
    RegData1_In   = v.a;
    RegData2_In   = v.b;
    ImmSignExt_In = v.imm;
    RTAddr_In     = v.rt;
    RDAddr_In     = v.rd;
  endtask

  task automatic idle_inputs();
    Valid_In = 1'b0; Flush_In = 1'b0; RegWriteEN_In = 1'b0; Mem2RegSEL_In = 1'b0;
    MemWriteEN_In = 1'b0; Branch_In = 1'b0; ALUCtrl_In = 4'd0; ALUSrc_In = 1'b0;
    RegDstSEL_In = 1'b0; RegData1_In = '0; RegData2_In = '0; ImmSignExt_In = '0;
    RTAddr_In = '0; RDAddr_In = '0;
  endtask

  // Drive an ADD (a + b, rd = 3) at the current drive point.
  task automatic drive_add(input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    Valid_In = 1'b1; RegWriteEN_In = 1'b1; RegDstSEL_In = 1'b1; RDAddr_In = 5'd3;
    ALUCtrl_In = 4'd0; RegData1_In = a; RegData2_In = b;
  endtask

  task automatic drive_mul(input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    Valid_In = 1'b1; RegWriteEN_In = 1'b1; RegDstSEL_In = 1'b1; RDAddr_In = 5'd7;
    ALUCtrl_In = 4'd10; RegData1_In = a; RegData2_In = b;
  endtask

  // Full MUL: 33 stall cycles with bubbles, then a one-cycle result pulse.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int stall_cycles;
    int bad_valid;
    stall_cycles = 0;
    bad_valid = 0;
    drive_mul(a, b);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!Stall_Out) break;
      stall_cycles++;
      if (i > 0 && Valid_Out) bad_valid++;
      @(negedge CLOCK);
    end
    chk("mul stall cycles", stall_cycles, 33);
    chk("mul valid during stall", bad_valid, 0);
    chk("mul valid in done cycle", Valid_Out, 1'b0);
    @(negedge CLOCK);
    chk("mul result", ALUResult_Out, exp);
    chk("mul valid", Valid_Out, 1'b1);
    chk("mul waddr", WriteAddr_Out, 5'd7);
    chk("mul regwrite", RegWriteEN_Out, 1'b1);
    idle_inputs();
    @(negedge CLOCK);
    chk("mul valid one cycle", Valid_Out, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    //          v  br rw mw m2r src dst op     a             b             imm           rt    rd      ev e_res         z  bt wa    rw mw m2r store
    vecs[0]  = '{1, 0, 1, 0, 0, 0, 1, 4'd0,  32'd5,        32'd7,        32'd0,        5'd9, 5'd3,   1, 32'd12,        0, 0, 5'd3, 1, 0, 0, 32'd7};
    vecs[1]  = '{1, 0, 1, 0, 0, 1, 0, 4'd6,  32'hFFFFFFFF, 32'd0,        32'd1,        5'd9, 5'd3,   1, 32'd1,         0, 0, 5'd9, 1, 0, 0, 32'd0};
    vecs[2]  = '{1, 0, 1, 0, 0, 1, 0, 4'd1,  32'hFFFFFFFF, 32'd0,        32'd1,        5'd9, 5'd3,   1, 32'hFFFFFFFE,  0, 0, 5'd9, 1, 0, 0, 32'd0};
    vecs[3]  = '{1, 1, 0, 0, 0, 0, 0, 4'd1,  32'h1234,     32'h1234,     32'd0,        5'd9, 5'd3,   1, 32'd0,         1, 1, 5'd9, 0, 0, 0, 32'h1234};
    vecs[4]  = '{0, 1, 1, 1, 0, 0, 0, 4'd1,  32'h1234,     32'h1234,     32'd0,        5'd9, 5'd3,   0, 32'd0,         1, 0, 5'd9, 0, 0, 0, 32'h1234};
    vecs[5]  = '{1, 0, 1, 0, 0, 0, 1, 4'd2,  32'hF0F000FF, 32'h0FF00F0F, 32'd0,        5'd9, 5'd3,   1, 32'h00F0000F,  0, 0, 5'd3, 1, 0, 0, 32'h0FF00F0F};
    vecs[6]  = '{1, 0, 1, 0, 0, 0, 1, 4'd3,  32'hF0F000FF, 32'h0FF00F0F, 32'd0,        5'd9, 5'd3,   1, 32'hFFF00FFF,  0, 0, 5'd3, 1, 0, 0, 32'h0FF00F0F};
    vecs[7]  = '{1, 0, 1, 0, 0, 0, 1, 4'd4,  32'hF0F000FF, 32'h0FF00F0F, 32'd0,        5'd9, 5'd3,   1, 32'hFF000FF0,  0, 0, 5'd3, 1, 0, 0, 32'h0FF00F0F};
    vecs[8]  = '{1, 0, 1, 0, 0, 0, 1, 4'd5,  32'd0,        32'd0,        32'd0,        5'd9, 5'd3,   1, 32'hFFFFFFFF,  0, 0, 5'd3, 1, 0, 0, 32'd0};
    vecs[9]  = '{1, 0, 1, 0, 0, 0, 1, 4'd7,  32'h24,       32'd1,        32'd0,        5'd9, 5'd3,   1, 32'h10,        0, 0, 5'd3, 1, 0, 0, 32'd1};
    vecs[10] = '{1, 0, 1, 0, 0, 0, 1, 4'd8,  32'd4,        32'h80000000, 32'd0,        5'd9, 5'd3,   1, 32'h08000000,  0, 0, 5'd3, 1, 0, 0, 32'h80000000};
    vecs[11] = '{1, 0, 1, 0, 0, 0, 1, 4'd9,  32'd4,        32'h80000000, 32'd0,        5'd9, 5'd3,   1, 32'hF8000000,  0, 0, 5'd3, 1, 0, 0, 32'h80000000};
    vecs[12] = '{1, 0, 1, 0, 0, 0, 1, 4'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        5'd9, 5'd3,   1, 32'd0,         1, 0, 5'd3, 1, 0, 0, 32'd1};
    vecs[13] = '{1, 1, 0, 0, 0, 0, 1, 4'd12, 32'd5,        32'd7,        32'd0,        5'd9, 5'd3,   1, 32'd0,         1, 1, 5'd3, 0, 0, 0, 32'd7};
    vecs[14] = '{1, 0, 1, 0, 0, 1, 0, 4'd6,  32'd5,        32'd0,        32'hFFFFFFFF, 5'd9, 5'd3,   1, 32'd0,         1, 0, 5'd9, 1, 0, 0, 32'd0};
    vecs[15] = '{1, 0, 0, 1, 1, 1, 0, 4'd0,  32'd100,      32'hDEADBEEF, 32'd8,        5'd9, 5'd3,   1, 32'd108,       0, 0, 5'd9, 0, 1, 1, 32'hDEADBEEF};

    RESET_N = 1'b0;
    idle_inputs();
    #2;
    chk("reset valid", Valid_Out, 1'b0);
    chk("reset result", ALUResult_Out, 32'd0);
    chk("reset stall", Stall_Out, 1'b0);
    chk("reset waddr", WriteAddr_Out, 5'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), Stall_Out, 1'b0);
      @(negedge CLOCK);
      chk($sformatf("v%0d valid", i), Valid_Out, vecs[i].e_valid);
      chk($sformatf("v%0d result", i), ALUResult_Out, vecs[i].e_res);
      chk($sformatf("v%0d zero", i), Zero_Out, vecs[i].e_zero);
      chk($sformatf("v%0d branch", i), BranchTaken_Out, vecs[i].e_bt);
      chk($sformatf("v%0d waddr", i), WriteAddr_Out, vecs[i].e_waddr);
      chk($sformatf("v%0d regwrite", i), RegWriteEN_Out, vecs[i].e_rw);
      chk($sformatf("v%0d memwrite", i), MemWriteEN_Out, vecs[i].e_mw);
      chk($sformatf("v%0d mem2reg", i), Mem2RegSEL_Out, vecs[i].e_m2r);
      chk($sformatf("v%0d store", i), StoreData_Out, vecs[i].e_store);
      idle_inputs();
    end

    @(negedge CLOCK);
    run_mul(32'd6, 32'd7, 32'd42);
    run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);

    // Flush at the 10th BUSY cycle.
    @(negedge CLOCK);
    drive_mul(32'd3, 32'd5);
    #1;
    chk("flush issue stall", Stall_Out, 1'b1);
    repeat (10) @(negedge CLOCK);
    #1;
    chk("flush busy stall", Stall_Out, 1'b1);
    Flush_In = 1'b1;
    #1;
    chk("flush stall drop", Stall_Out, 1'b0);
    @(negedge CLOCK);
    drive_add(32'd2, 32'd3);
    #1;
    chk("post-flush stall", Stall_Out, 1'b0);
    chk("post-flush bubble", Valid_Out, 1'b0);
    @(negedge CLOCK);
    chk("post-flush add valid", Valid_Out, 1'b1);
    chk("post-flush add result", ALUResult_Out, 32'd5);
    idle_inputs();
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge CLOCK);
      if (Valid_Out) pulses++;
    end
    chk("flush no product", pulses, 0);

    // Asynchronous reset in the middle of a MUL; inputs keep presenting it.
    drive_mul(32'd9, 32'd9);
    repeat (5) @(negedge CLOCK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid-mul reset valid", Valid_Out, 1'b0);
    chk("mid-mul reset result", ALUResult_Out, 32'd0);
    chk("mid-mul reset store", StoreData_Out, 32'd0);
    chk("mid-mul reset waddr", WriteAddr_Out, 5'd0);
    chk("mid-mul reset regwrite", RegWriteEN_Out, 1'b0);
    chk("mid-mul reset stall", Stall_Out, 1'b0);
    idle_inputs();
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(negedge CLOCK);
    drive_add(32'd10, 32'd20);
    #1;
    chk("post-reset stall", Stall_Out, 1'b0);
    @(negedge CLOCK);
    chk("post-reset add valid", Valid_Out, 1'b1);
    chk("post-reset add result", ALUResult_Out, 32'd30);
    chk("post-reset add waddr", WriteAddr_Out, 5'd3);
    idle_inputs();
    @(negedge CLOCK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs.
- Selects ALU operands, computes ALU result, zero flag and branch decision, and resolves the destination register.
- Registers results into the EX/MEM boundary.
- Contains an iterative 32-cycle multiplier; while it runs, the block stalls upstream and inserts bubbles downstream.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.
- MUL_ITERS, 32, multiplier iterations; must equal DATA_W.

Ports:
- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- Valid_In  in  1  ID/EX slot holds a real instruction
- Flush_In  in  1  kill the current EX instruction
- RegWriteEN_In  in  1  register write enable
- Mem2RegSEL_In  in  1  writeback source select (1 = memory)
- MemWriteEN_In  in  1  memory write enable
- Branch_In  in  1  instruction is a branch (BEQ)
- ALUCtrl_In  in  4  ALU operation code
- ALUSrc_In  in  1  operand B select: 1 = ImmSignExt_In, 0 = RegData2_In
- RegDstSEL_In  in  1  destination select: 1 = RD, 0 = RT
- RegData1_In  in  DATA_W  operand A
- RegData2_In  in  DATA_W  rt value
- ImmSignExt_In  in  DATA_W  sign-extended immediate
- RTAddr_In  in  ADDR_W  rt address
- RDAddr_In  in  ADDR_W  rd address
- Stall_Out  out  1  combinational; upstream holds ID/EX contents while high
- Valid_Out  out  1  EX/MEM slot valid
- RegWriteEN_Out  out  1  registered
- Mem2RegSEL_Out  out  1  registered
- MemWriteEN_Out  out  1  registered
- BranchTaken_Out  out  1  registered
- Zero_Out  out  1  registered
- ALUResult_Out  out  DATA_W  registered
- StoreData_Out  out  DATA_W  registered RegData2_In
- WriteAddr_Out  out  ADDR_W  registered

Behaviour:
- Reset (async, RESET_N low):
  - every registered output = 0;
  - FSM = IDLE, multiplier counter = 0;
  - Stall_Out = 0.
- Datapath:
  - B = ALUSrc_In ? ImmSignExt_In : RegData2_In.
  - WriteAddr = RegDstSEL_In ? RDAddr_In : RTAddr_In.
- ALUCtrl codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR;
  - 6 SLT (signed; result 1 or 0);
  - 7 SLL B<<A[4:0], 8 SRL, 9 SRA;
  - 10 MUL (low DATA_W bits of A*B);
  - 11-15: result 0.
- Arithmetic wraps modulo 2^DATA_W; no overflow trap.
- Zero = (result == 0).
- BranchTaken = Valid & Branch_In & Zero.
- Single-cycle ops, latency 1: in IDLE, with Valid_In=1 and op != MUL, the result plus all control/address/store fields are registered at the next edge with Valid_Out=1.
- Bubble: when Valid_In=0, the next edge registers Valid_Out=0 with RegWriteEN, MemWriteEN and BranchTaken forced to 0. Data fields are don't-care and are held.
- FSM IDLE:
  - Valid_In and op == MUL: Stall_Out=1 combinationally; latch A and B into the multiplier; go to BUSY; register a bubble.
- FSM BUSY:
  - Stall_Out=1; one shift-add step per cycle;
  - the counter increments and goes to DONE after MUL_ITERS steps;
  - a bubble is registered each cycle.
- FSM DONE:
  - Stall_Out=0; the held ID/EX inputs provide the control fields;
  - the product is registered with Valid_Out=1; return to IDLE.
- MUL timing: issue seen at cycle T; Stall_Out high for cycles T..T+32 (33 cycles); result visible after the edge ending cycle T+33.
- Flush_In has highest priority:
  - the next edge registers a bubble;
  - BUSY or DONE aborts to IDLE, counter cleared, no product delivered;
  - Stall_Out is forced 0 in that same cycle.
- Reset mid-multiply: immediate return to IDLE, no partial output.
- Valid_In dropping while BUSY: illegal; upstream guarantees the hold.

Decomposition:
- Shared package ex_pkg:
  - ALU opcode constants (ALU_ADD..ALU_MUL);
  - FSM state enum (IDLE, BUSY, DONE);
  - DATA_W/ADDR_W defaults.
- One sub-module: mul_iter (shift-add multiplier).
  - Ports: start, a, b, busy, done, product.
  - It includes a synchronous abort input driven by Flush_In.
- ALU stays inline as a combinational block.

Test Plan:
- ADD: Valid=1, A=5, RegData2=7, ALUSrc=0, RegDst=1, RD=3 -> next cycle ALUResult=12, WriteAddr=3, Valid_Out=1, Stall_Out=0 throughout.
- Immediate/SLT: A=0xFFFFFFFF, Imm=1, ALUSrc=1, op SLT -> ALUResult=1. Same operands with op SUB -> 0xFFFFFFFE, Zero=0.
- Branch: Branch=1, SUB, A=B=0x1234 -> Zero_Out=1, BranchTaken_Out=1. Same stimulus with Valid_In=0 -> BranchTaken_Out=0, Valid_Out=0.
- MUL 6*7:
  - Stall_Out high for exactly 33 cycles and Valid_Out=0 during the stall;
  - then ALUResult=42, Valid_Out=1 for one cycle.
  - 0xFFFFFFFF*2 gives 0xFFFFFFFE.
- Flush mid-MUL, Flush_In at the 10th BUSY cycle:
  - Stall_Out drops the same cycle and the FSM returns to IDLE;
  - no Valid_Out pulse;
  - a following ADD completes with latency 1.
- Reset: RESET_N low mid-MUL and asynchronous to CLOCK -> all outputs 0 immediately, Stall_Out=0; after release an ADD behaves normally.
